// File: rtl/pmem_arbiter.sv
// Arbitrates the single physical-memory port between the I-cache and the D-cache.
// Each grant covers one cacheline transaction, with an IDLE cycle between transactions.
module pmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              grant_d
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] I_SERVE = 2'd1;
  localparam logic [1:0] D_SERVE = 2'd2;

  logic [1:0]        state;
  logic              op_wr;
  logic              last_grant;
  logic              d_lock;
  logic [ADDR_W-1:0] addr_q;
  logic              d_req;
  logic              pick_d;

  // D wins when locked, when I is quiet, or when I held the last grant.
  always_comb begin
    d_req  = d_pmem_read | d_pmem_write;
    pick_d = d_req & (d_lock | ~i_pmem_read | ~last_grant);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op_wr      <= 1'b0;
      addr_q     <= '0;
      last_grant <= 1'b0;
      d_lock     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          d_lock <= 1'b0;
          if (pick_d) begin
            state      <= D_SERVE;
            addr_q     <= d_pmem_address;
            op_wr      <= d_pmem_write;
            last_grant <= 1'b1;
          end else if (i_pmem_read) begin
            state      <= I_SERVE;
            addr_q     <= i_pmem_address;
            op_wr      <= 1'b0;
            last_grant <= 1'b0;
          end
        end
        I_SERVE: begin
          if (pmem_resp) state <= IDLE;
        end
        D_SERVE: begin
          if (pmem_resp) begin
            state  <= IDLE;
            // A write-back must be followed by its fill without an I interleave.
            d_lock <= op_wr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_rdata = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_rdata = '0;
    d_pmem_resp  = 1'b0;
    grant_d      = 1'b0;
    case (state)
      I_SERVE: begin
        pmem_read    = 1'b1;
        pmem_address = addr_q;
        i_pmem_rdata = pmem_rdata;
        i_pmem_resp  = pmem_resp;
      end
      D_SERVE: begin
        pmem_write   = op_wr;
        pmem_read    = ~op_wr;
        pmem_address = addr_q;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_rdata = pmem_rdata;
        d_pmem_resp  = pmem_resp;
        grant_d      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level ownership model.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         grant_d;

  int compared   = 0;
  int mismatched = 0;

  pmem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  task automatic chkb(input string nm, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chka(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkl(input string nm, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the port (0 nobody, 1 I-cache, 2 D-cache) and what it asked for.
  int          owner = 0;
  int          last_side = 1;
  bit          lock = 0;
  logic [31:0] own_addr = '0;
  bit          own_wr = 0;

  task automatic model_reset();
    owner = 0; last_side = 1; lock = 0; own_addr = '0; own_wr = 0;
  endtask

  task automatic model_step();
    bit dwants, iwants;
    int pick;
    if (!rst) begin
      model_reset();
      return;
    end
    if (owner == 0) begin
      dwants = d_pmem_read || d_pmem_write;
      iwants = i_pmem_read;
      pick = 0;
      if (lock && dwants)       pick = 2;
      else if (dwants && iwants) pick = (last_side == 2) ? 1 : 2;
      else if (dwants)           pick = 2;
      else if (iwants)           pick = 1;
      lock = 0;
      if (pick == 2) begin
        owner = 2; own_addr = d_pmem_address; own_wr = d_pmem_write; last_side = 2;
      end else if (pick == 1) begin
        owner = 1; own_addr = i_pmem_address; own_wr = 0; last_side = 1;
      end
    end else if (pmem_resp) begin
      if (owner == 2 && own_wr) lock = 1;
      owner = 0;
    end
  endtask

  task automatic model_compare();
    logic [4:0] cmd_exp;
    if (!rst) model_reset();
    cmd_exp = {owner == 1 || (owner == 2 && !own_wr), owner == 2 && own_wr, owner == 2,
               owner == 1 && pmem_resp, owner == 2 && pmem_resp};
    chka("model_cmd", {27'd0, pmem_read, pmem_write, grant_d, i_pmem_resp, d_pmem_resp},
         {27'd0, cmd_exp});
    chka("model_addr", pmem_address, (owner != 0) ? own_addr : 32'd0);
    chkl("model_wdata", pmem_wdata, (owner == 2) ? d_pmem_wdata : '0);
    chkl("model_i_rdata", i_pmem_rdata, (owner == 1) ? pmem_rdata : '0);
    chkl("model_d_rdata", d_pmem_rdata, (owner == 2) ? pmem_rdata : '0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      model_compare();
    end
  end

  logic [255:0] r1, r2, w1;

  initial begin
    rst = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
    d_pmem_read = 1'b1; d_pmem_write = 1'b0; d_pmem_address = 32'h0000_2040;
    d_pmem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    r1 = rand_line(); r2 = rand_line(); w1 = rand_line();

    // Reset held with both requesting: everything quiet.
    tick();
    pmem_rdata = r1;
    @(negedge clk);
    chkb("rst_read", pmem_read, 1'b0);
    chkb("rst_write", pmem_write, 1'b0);
    chkb("rst_grant", grant_d, 1'b0);
    chka("rst_addr", pmem_address, 32'h0);
    chkl("rst_i_rdata", i_pmem_rdata, '0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chkb("idle_after_rst", pmem_read, 1'b0);

    // First tie after reset goes to D at 0x2040.
    tick();
    d_pmem_read = 1'b0;
    @(negedge clk);
    chkb("tie_grant_d", grant_d, 1'b1);
    chka("tie_addr", pmem_address, 32'h0000_2040);
    chkb("tie_read", pmem_read, 1'b1);
    tick();
    pmem_resp = 1'b1; pmem_rdata = r1;
    @(negedge clk);
    chkb("d_resp", d_pmem_resp, 1'b1);
    chkl("d_rdata", d_pmem_rdata, r1);
    chkb("i_resp_quiet", i_pmem_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    @(negedge clk);
    chkb("bubble", pmem_read, 1'b0);

    // I read served for five cycles, response on the fifth.
    tick();
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) begin
        pmem_resp = 1'b1; pmem_rdata = r2; i_pmem_read = 1'b0;
        i_pmem_address = 32'hDEAD_0000;
      end
      @(negedge clk);
      chkb("i_read_held", pmem_read, 1'b1);
      chka("i_addr", pmem_address, 32'h0000_1000);
      chkb("i_resp_timing", i_pmem_resp, k == 5);
      if (k == 5) begin
        chkl("i_rdata", i_pmem_rdata, r2);
        chkb("d_resp_quiet", d_pmem_resp, 1'b0);
      end
      tick();
    end
    pmem_resp = 1'b0;

    // Write-back 0x80 then its fill 0x40 while I keeps asking.
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0080; d_pmem_wdata = w1;
    tick();
    pmem_resp = 1'b1;
    d_pmem_write = 1'b0; d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0040;
    @(negedge clk);
    chkb("wb_write", pmem_write, 1'b1);
    chkb("wb_read", pmem_read, 1'b0);
    chka("wb_addr", pmem_address, 32'h0000_0080);
    chkl("wb_wdata", pmem_wdata, w1);
    tick();
    pmem_resp = 1'b0;
    tick();
    pmem_resp = 1'b1; d_pmem_read = 1'b0;
    @(negedge clk);
    chkb("fill_grant_d", grant_d, 1'b1);
    chkb("fill_write", pmem_write, 1'b0);
    chka("fill_addr", pmem_address, 32'h0000_0040);
    tick();
    pmem_resp = 1'b0;
    tick();
    pmem_resp = 1'b1;
    @(negedge clk);
    chka("after_fill_i_addr", pmem_address, 32'h0000_1000);
    chkb("after_fill_grant", grant_d, 1'b0);
    tick();
    pmem_resp = 1'b0;

    // Continuous contention alternates D, I, D, I, D, I.
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_3000;
    for (int t = 0; t < 6; t++) begin
      tick();
      pmem_resp = 1'b1;
      @(negedge clk);
      chkb("rr_grant", grant_d, (t % 2) == 0);
      tick();
      pmem_resp = 1'b0;
    end

    // Reset in the middle of a write-back.
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0300;
    tick();
    @(negedge clk);
    chkb("pre_rst_write", pmem_write, 1'b1);
    #1 rst = 1'b0; pmem_resp = 1'b1;
    #1;
    chkb("rst_drop_write", pmem_write, 1'b0);
    chkb("rst_no_d_resp", d_pmem_resp, 1'b0);
    tick();
    rst = 1'b1; pmem_resp = 1'b0;
    d_pmem_write = 1'b0; d_pmem_read = 1'b1; i_pmem_read = 1'b1;
    tick();
    @(negedge clk);
    chkb("post_rst_grant_d", grant_d, 1'b1);
    chka("post_rst_addr", pmem_address, 32'h0000_0300);

    // Random traffic, spurious responses and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst            = ($urandom_range(0, 99) != 0);
      i_pmem_read    = ($urandom_range(0, 2) != 0);
      d_pmem_read    = ($urandom_range(0, 2) == 0);
      d_pmem_write   = ($urandom_range(0, 3) == 0);
      i_pmem_address = $urandom();
      d_pmem_address = $urandom();
      d_pmem_wdata   = rand_line();
      pmem_rdata     = rand_line();
      pmem_resp      = ($urandom_range(0, 9) < 3);
    end

    tick();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
